demux_1to2_stream: RTL and testbench
====================================

// Module: demux_1to2_stream
// PURPOSE
//  - Steers one 16-bit datapath stream to one of two destinations with valid/ready handshake.
//  - Complements the core's 2-to-1 operand mux on the distribution side.
//    Typical use: routes writeback/result data to the register-file port (dest 0)
//    or the memory/IO port (dest 1), registering each output.
//  - Each destination owns a one-entry output register, so a stalled destination never
//    blocks traffic headed to the other one.
// PARAMETERS
//  WIDTH    16   data width of in_data / out0_data / out1_data
//  CNT_W    8    width of the per-destination transfer counters (wrap-around)
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high reset
//  in_valid    in   1      upstream presents in_data/in_sel this cycle
//  in_ready    out  1      block accepts in_data this cycle (combinational)
//  in_sel      in   1      destination select: 0 -> out0, 1 -> out1
//  in_data     in   WIDTH  payload
//  out0_valid  out  1      out0_data holds an unconsumed word
//  out0_ready  in   1      destination 0 consumes the word this cycle
//  out0_data   out  WIDTH  registered payload for destination 0
//  out1_valid  out  1      same as out0_valid, for destination 1
//  out1_ready  in   1      same as out0_ready, for destination 1
//  out1_data   out  WIDTH  same as out0_data, for destination 1
//  cnt0        out  CNT_W  count of completed out0 transfers (valid&&ready)
//  cnt1        out  CNT_W  count of completed out1 transfers
// BEHAVIOUR
//  - Reset state: outN_valid=0, outN_data=0, cntN=0.
//    Any buffered word is discarded; this includes a reset asserted mid-transfer.
//    While reset=1, in_ready is forced to 0.
//  - Per-slot state: EMPTY (valid=0) or FULL (valid=1).
//  - Slot free condition: freeN = !outN_valid || outN_ready.
//  - in_ready = !reset && (in_sel ? free1 : free0).
//    in_ready depends combinationally on in_sel and outN_ready; it has no dependency on in_valid.
//  - Accept: acc = in_valid && in_ready. The word is written into slot in_sel at the clock edge.
//  - Latency: data is visible on outN_data exactly 1 cycle after acceptance.
//  - Throughput: one word per cycle sustained when the selected slot is drained every cycle.
//  - Slot N next state:
//    - load (acc && in_sel==N):   valid<=1, data<=in_data. This applies even if the slot is
//      draining the same cycle (simultaneous drain+load).
//    - drain only (outN_valid && outN_ready, no load): valid<=0; data holds its last value.
//    - otherwise: hold.
//  - Both slots may drain in the same cycle while a third word loads one of them.
//    All three events are legal and independent.
//  - outN_data and outN_valid must stay stable while outN_valid && !outN_ready.
//  - Ordering: words to the same destination leave in arrival order.
//    There is no ordering guarantee across the two destinations.
//  - Counters: cntN increments by 1 on each outN_valid && outN_ready.
//    Wraps from 2^CNT_W-1 to 0 with no flag.
//  - in_sel and in_data are ignored when in_valid=0.
// STRUCTURE
//  - Sub-module out_slot (WIDTH, CNT_W), instantiated twice.
//    - Ports: clk, reset, load, load_data, ready, valid, data, free, cnt.
//    - Holds the one-entry register, the free logic, and the transfer counter.
//  - Top level holds only the in_sel decode, in_ready select, and per-slot load strobes.
//  - Shared constants (DATA_W=16, SEL_RF=1'b0, SEL_MEM=1'b1) go in the core's common
//    defines header. No new typedefs.
// TESTING
//  1. Reset. Hold reset 3 cycles with in_valid=1.
//     -> in_ready=0, out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0.
//  2. Single route. in_sel=0, in_data=16'hA5A5, out0_ready=0.
//     -> next cycle out0_valid=1, out0_data=A5A5, out1_valid=0.
//     Raise out0_ready -> cnt0=1, out0_valid=0.
//  3. Back-pressure isolation. out0 full with out0_ready=0; send in_sel=1, 16'h1234.
//     -> in_ready=1, out1_data=1234 one cycle later.
//     Then send in_sel=0 -> in_ready=0 until out0_ready=1.
//  4. Streaming. out0_ready=1 constantly; send 16'h0001..16'h0010 to dest 0 on
//     consecutive cycles.
//     -> out0_data sequence identical and in order, one per cycle; cnt0=16.
//  5. Simultaneous. Both slots full, out0_ready=out1_ready=1, in_sel=1, 16'hBEEF.
//     -> both drain, out1 reloads with BEEF (out1_valid stays 1), out0_valid=0;
//     cnt0 and cnt1 each increment.
//  6. Wrap and reset mid-op. Preload cnt0=255 via 255 transfers, do one more -> cnt0=0.
//     Then fill out1 and assert reset for 1 cycle -> out1_valid=0, word lost, cnt1=0.

Source files
------------

// File: rtl/demux_1to2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demux.
//   DATA_W  : default payload width
//   CNT_W   : default transfer-counter width
//   SEL_RF  : in_sel value routing to destination 0 (register-file port)
//   SEL_MEM : in_sel value routing to destination 1 (memory/IO port)
package demux_1to2_stream_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 8;
    localparam logic        SEL_RF  = 1'b0;
    localparam logic        SEL_MEM = 1'b1;

endpackage : demux_1to2_stream_pkg

// File: rtl/demux_1to2_stream_out_slot.sv
// One-entry output register for a single demux destination (the out_slot block).
//   clk, reset : clock and synchronous active-high reset
//   load       : write load_data into the slot at the next edge
//   load_data  : payload to capture
//   ready      : destination consumes the held word this cycle
//   valid      : slot holds an unconsumed word (registered)
//   data       : held payload (registered)
//   free       : slot can take a word this cycle (combinational)
//   cnt        : wrap-around count of completed valid&&ready transfers (registered)
module demux_1to2_stream_out_slot
    import demux_1to2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = demux_1to2_stream_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    assign drain = valid && ready;

    // A draining slot is free in the same cycle, enabling one word per cycle.
    assign free = !valid || ready;

    // Load wins over drain so a simultaneous drain+load leaves the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (drain) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule : demux_1to2_stream_out_slot

// File: rtl/demux_1to2_stream.sv
// Steers one valid/ready stream to one of two registered destinations.
//   clk, reset            : clock and synchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready combinational, 0 in reset)
//   in_sel                : 0 -> out0, 1 -> out1
//   in_data               : payload
//   outN_valid/outN_ready : per-destination handshake
//   outN_data             : registered payload per destination
//   cnt0, cnt1            : wrap-around completed-transfer counters
module demux_1to2_stream
    import demux_1to2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = demux_1to2_stream_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic free0;
    logic free1;
    logic acc;
    logic load0;
    logic load1;

    // Readiness follows only the selected slot, so a stalled destination
    // never blocks traffic to the other one.
    assign in_ready = !reset && ((in_sel == SEL_MEM) ? free1 : free0);
    assign acc      = in_valid && in_ready;
    assign load0    = acc && (in_sel == SEL_RF);
    assign load1    = acc && (in_sel == SEL_MEM);

    demux_1to2_stream_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .free      (free0),
        .cnt       (cnt0)
    );

    demux_1to2_stream_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .free      (free1),
        .cnt       (cnt1)
    );

endmodule : demux_1to2_stream

// File: tb/tb_demux_1to2_stream.sv
// Testbench for demux_1to2_stream: directed stimulus, queue scoreboard,
// and a negedge monitor that checks every delivered word and both counters.
module tb_demux_1to2_stream;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [15:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_data;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    int n_cmp;
    int n_bad;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [7:0]  mcnt0;
    logic [7:0]  mcnt1;
    bit          armed;

    demux_1to2_stream dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard producer: every accepted word is queued for its destination.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            if (in_sel) exp_q1.push_back(in_data);
            else        exp_q0.push_back(in_data);
        end
    end

    // Monitor: checks held words and counters, then retires the transfers
    // that the upcoming rising edge completes.
    always @(negedge clk) begin
        if (armed) begin
            chk("mon_cnt0", 32'(cnt0), 32'(mcnt0));
            chk("mon_cnt1", 32'(cnt1), 32'(mcnt1));
            if (out0_valid) begin
                if (exp_q0.size() == 0) chk("mon_q0_underflow", 32'(1), 32'(0));
                else                    chk("mon_out0_data", 32'(out0_data), 32'(exp_q0[0]));
            end
            if (out1_valid) begin
                if (exp_q1.size() == 0) chk("mon_q1_underflow", 32'(1), 32'(0));
                else                    chk("mon_out1_data", 32'(out1_data), 32'(exp_q1[0]));
            end
        end
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            mcnt0 = 8'd0;
            mcnt1 = 8'd0;
            armed = 1'b1;
        end else begin
            if (out0_valid && out0_ready && exp_q0.size() != 0) begin
                void'(exp_q0.pop_front());
                mcnt0 = mcnt0 + 8'd1;
            end
            if (out1_valid && out1_ready && exp_q1.size() != 0) begin
                void'(exp_q1.pop_front());
                mcnt1 = mcnt1 + 8'd1;
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        armed      = 1'b0;
        mcnt0      = 8'd0;
        mcnt1      = 8'd0;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 16'hFFFF;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // 1. Reset held 3 cycles with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 32'(in_ready), 32'(0));
            tick();
        end
        chk("rst_out0_valid", 32'(out0_valid), 32'(0));
        chk("rst_out1_valid", 32'(out1_valid), 32'(0));
        chk("rst_out0_data", 32'(out0_data), 32'(0));
        chk("rst_out1_data", 32'(out1_data), 32'(0));
        chk("rst_cnt0", 32'(cnt0), 32'(0));
        chk("rst_cnt1", 32'(cnt1), 32'(0));
        reset = 1'b0;

        // 2. Single route to dest 0.
        in_sel  = 1'b0;
        in_data = 16'hA5A5;
        #1;
        chk("t2_in_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        chk("t2_out0_valid", 32'(out0_valid), 32'(1));
        chk("t2_out0_data", 32'(out0_data), 32'h0000A5A5);
        chk("t2_out1_valid", 32'(out1_valid), 32'(0));
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        chk("t2_cnt0", 32'(cnt0), 32'(1));
        chk("t2_out0_valid_drained", 32'(out0_valid), 32'(0));

        // 3. Back-pressure isolation.
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'h5555;
        tick();
        in_sel  = 1'b1;
        in_data = 16'h1234;
        #1;
        chk("t3_in_ready_dest1", 32'(in_ready), 32'(1));
        tick();
        chk("t3_out1_valid", 32'(out1_valid), 32'(1));
        chk("t3_out1_data", 32'(out1_data), 32'h00001234);
        in_sel  = 1'b0;
        in_data = 16'h7777;
        #1;
        chk("t3_in_ready_blocked", 32'(in_ready), 32'(0));
        tick();
        chk("t3_in_ready_still_blocked", 32'(in_ready), 32'(0));
        chk("t3_out0_data_stable", 32'(out0_data), 32'h00005555);
        out0_ready = 1'b1;
        #1;
        chk("t3_in_ready_released", 32'(in_ready), 32'(1));
        tick();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        chk("t3_out0_data_next", 32'(out0_data), 32'h00007777);
        chk("t3_cnt0", 32'(cnt0), 32'(2));

        // 5. Simultaneous: both full, both drain, dest 1 reloads.
        chk("t5_pre_out0_valid", 32'(out0_valid), 32'(1));
        chk("t5_pre_out1_valid", 32'(out1_valid), 32'(1));
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 16'hBEEF;
        tick();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        chk("t5_out1_valid", 32'(out1_valid), 32'(1));
        chk("t5_out1_data", 32'(out1_data), 32'h0000BEEF);
        chk("t5_out0_valid", 32'(out0_valid), 32'(0));
        chk("t5_cnt0", 32'(cnt0), 32'(3));
        chk("t5_cnt1", 32'(cnt1), 32'(1));
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        chk("t5_cnt1_drain", 32'(cnt1), 32'(2));

        // 4. Streaming 16 words to dest 0, one per cycle.
        out0_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_data = 16'(i);
            #1;
            chk("t4_in_ready", 32'(in_ready), 32'(1));
            tick();
            chk("t4_out0_data", 32'(out0_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t4_cnt0", 32'(cnt0), 32'(19));
        chk("t4_out0_valid", 32'(out0_valid), 32'(0));

        // 6. Counter wrap: 236 more transfers reach 255, one more wraps to 0.
        in_valid = 1'b1;
        for (int i = 0; i < 236; i++) begin
            in_data = 16'(16'h4000 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_cnt0_255", 32'(cnt0), 32'(255));
        in_valid = 1'b1;
        in_data  = 16'hD00D;
        tick();
        in_valid = 1'b0;
        tick();
        out0_ready = 1'b0;
        chk("t6_cnt0_wrap", 32'(cnt0), 32'(0));

        // Reset mid-operation discards a buffered word.
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'hCAFE;
        tick();
        in_valid = 1'b0;
        chk("t6_out1_filled", 32'(out1_valid), 32'(1));
        reset = 1'b1;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'(0));
        tick();
        reset = 1'b0;
        chk("t6_out1_valid_lost", 32'(out1_valid), 32'(0));
        chk("t6_out1_data_clr", 32'(out1_data), 32'(0));
        chk("t6_cnt1_clr", 32'(cnt1), 32'(0));
        tick();
        tick();
        chk("end_q0_empty", 32'(exp_q0.size()), 32'(0));
        chk("end_q1_empty", 32'(exp_q1.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_demux_1to2_stream
